alu_exec_stage: RTL and testbench

- Registered execute stage of the ALU: accepts an operation and two operands over a valid/ready handshake and returns a registered result over a second valid/ready handshake.
- Single-cycle ops (add/sub/logic/compare) are computed by the existing per-operation combinational units: the AND, OR and XOR bitwise units plus the adder.
- Shifts use an iterative 1-bit-per-cycle serial shifter to save area.
- Sits between decode/operand-fetch (upstream) and the EX/MEM pipeline register (downstream).

---
 rtl/alu_exec_stage_pkg.sv | 40 ++++
 rtl/alu_exec_stage_if.sv | 25 ++
 rtl/alu_serial_shifter.sv | 61 ++++++
 rtl/alu_exec_stage.sv | 132 +++++++++++++
 tb/tb_alu_exec_stage.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_exec_stage_pkg.sv
// Shared definitions for the ALU execute stage: op codes, FSM encodings,
// default widths and the shift-type helpers.
package alu_exec_stage_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int SHAMT_W_DEF = 5;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    typedef enum logic [1:0] {
        SH_SLL,
        SH_SRL,
        SH_SRA
    } shift_type_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

    function automatic shift_type_e shift_type_of(input logic [3:0] op);
        case (op)
            ALU_SRL: return SH_SRL;
            ALU_SRA: return SH_SRA;
            default: return SH_SLL;
        endcase
    endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Upstream operation handshake and downstream result handshake of the execute stage.
interface alu_exec_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal_op;

    modport slave (
        input  in_valid, alu_op, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, illegal_op
    );

    modport master (
        output in_valid, alu_op, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal_op
    );
endinterface

// File: rtl/alu_serial_shifter.sv
// Iterative shifter: one bit position per cycle; done_o flags the cycle whose
// shifted value (result_o) is the final one.
module alu_serial_shifter
    import alu_exec_stage_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  shift_type_e        type_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic               done_o,
    output logic [WIDTH-1:0]   result_o
);

    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    shift_type_e        type_q, type_d;
    logic [WIDTH-1:0]   shifted;

    // NOTE: every variable gets a default before any branch so always_comb never infers a latch.
    always_comb begin
        case (type_q)
            SH_SRL:  shifted = {1'b0, acc_q[WIDTH-1:1]};
            SH_SRA:  shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            default: shifted = {acc_q[WIDTH-2:0], 1'b0};
        endcase

        acc_d  = acc_q;
        cnt_d  = cnt_q;
        type_d = type_q;
        if (start_i) begin
            acc_d  = data_i;
            cnt_d  = shamt_i;
            type_d = type_i;
        end else if (cnt_q != '0) begin
            acc_d = shifted;
            cnt_d = cnt_q - SHAMT_W'(1);
        end
    end

    assign done_o   = (cnt_q == SHAMT_W'(1));
    assign result_o = shifted;

    // NOTE: registers use <= so they all sample pre-edge values together.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            type_q <= SH_SLL;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            type_q <= type_d;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: single-cycle ops finish in one edge, non-zero
// shifts run through the serial shifter while the input side is stalled.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    alu_exec_stage_if.slave   bus_io
);

    logic [3:0]         op;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [SHAMT_W-1:0] shamt;
    logic               multi_cycle;
    logic               in_ready;
    logic               accept;

    logic [WIDTH-1:0]   add_res, sub_res, and_res, or_res, xor_res;
    logic [WIDTH-1:0]   comb_res;
    logic               comb_illegal;

    logic               sh_done;
    logic [WIDTH-1:0]   sh_res;

    logic [0:0]         state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               illegal_q, illegal_d;

    assign op    = bus_io.alu_op;
    assign op_a  = bus_io.op_a;
    assign op_b  = bus_io.op_b;
    assign shamt = op_b[SHAMT_W-1:0];

    assign multi_cycle = is_shift(op) && (shamt != '0);
    assign in_ready    = !reset && (state_q == ST_IDLE) && (!out_valid_q || bus_io.out_ready);
    assign accept      = bus_io.in_valid && in_ready;

    // Bitwise units and adder/subtractor.
    assign and_res = op_a & op_b;
    assign or_res  = op_a | op_b;
    assign xor_res = op_a ^ op_b;
    assign add_res = op_a + op_b;
    assign sub_res = op_a - op_b;

    always_comb begin
        comb_res     = '0;
        comb_illegal = 1'b0;
        case (op)
            ALU_ADD:  comb_res = add_res;
            ALU_SUB:  comb_res = sub_res;
            ALU_AND:  comb_res = and_res;
            ALU_OR:   comb_res = or_res;
            ALU_XOR:  comb_res = xor_res;
            ALU_SLT:  comb_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: comb_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            // Only reached for a zero shift amount: the operand passes through.
            ALU_SLL, ALU_SRL, ALU_SRA: comb_res = op_a;
            default:  comb_illegal = 1'b1;
        endcase
    end

    alu_serial_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .start_i  (accept && multi_cycle),
        .type_i   (shift_type_of(op)),
        .data_i   (op_a),
        .shamt_i  (shamt),
        .done_o   (sh_done),
        .result_o (sh_res)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;

        if (state_q == ST_IDLE) begin
            if (accept && multi_cycle) begin
                state_d     = ST_SHIFT;
                out_valid_d = 1'b0;
            end else if (accept) begin
                result_d    = comb_res;
                zero_d      = (comb_res == '0);
                illegal_d   = comb_illegal;
                out_valid_d = 1'b1;
            end else if (bus_io.out_ready) begin
                out_valid_d = 1'b0;
            end
        end else if (sh_done) begin
            result_d    = sh_res;
            zero_d      = (sh_res == '0);
            illegal_d   = 1'b0;
            out_valid_d = 1'b1;
            state_d     = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus_io.in_ready   = in_ready;
    assign bus_io.out_valid  = out_valid_q;
    assign bus_io.result     = result_q;
    assign bus_io.zero       = zero_q;
    assign bus_io.illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: an abstract cycle model checked against the DUT on
// every cycle, directed literal cases, then randomized traffic with resets.
module tb_alu_exec_stage;

    typedef struct packed {
        logic [31:0] val;
        logic        ill;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_exec_stage_if #(.WIDTH(32)) bus ();

    alu_exec_stage dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, straight from the op-code table.
    function automatic exp_t ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   sh;
        sh    = int'(b[4:0]);
        e.ill = 1'b0;
        case (op)
            4'd0: e.val = a + b;
            4'd1: e.val = a - b;
            4'd2: e.val = a & b;
            4'd3: e.val = a | b;
            4'd4: e.val = a ^ b;
            4'd5: e.val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: e.val = (a < b) ? 32'd1 : 32'd0;
            4'd7: e.val = a << sh;
            4'd8: e.val = a >> sh;
            4'd9: e.val = $signed(a) >>> sh;
            default: begin
                e.val = 32'd0;
                e.ill = 1'b1;
            end
        endcase
        return e;
    endfunction

    // Cycle model: busy counts remaining shift cycles, pend holds the shift answer.
    bit          m_started = 1'b0;
    logic        m_ov      = 1'b0;
    logic [31:0] m_res     = '0;
    logic        m_zero    = 1'b0;
    logic        m_ill     = 1'b0;
    int          m_busy    = 0;
    logic [31:0] m_pend    = '0;
    exp_t        m_e;
    logic        m_long;

    assign m_e    = ref_op(bus.alu_op, bus.op_a, bus.op_b);
    assign m_long = (bus.alu_op inside {4'd7, 4'd8, 4'd9}) && (bus.op_b[4:0] != 5'd0);

    always @(posedge clk) begin
        if (reset) begin
            m_started <= 1'b1;
            m_ov      <= 1'b0;
            m_res     <= '0;
            m_zero    <= 1'b0;
            m_ill     <= 1'b0;
            m_busy    <= 0;
        end else if (m_busy > 0) begin
            m_busy <= m_busy - 1;
            if (m_busy == 1) begin
                m_ov   <= 1'b1;
                m_res  <= m_pend;
                m_zero <= (m_pend == 32'd0);
                m_ill  <= 1'b0;
            end
        end else if (bus.in_valid && (!m_ov || bus.out_ready)) begin
            if (m_long) begin
                m_busy <= int'(bus.op_b[4:0]);
                m_pend <= m_e.val;
                m_ov   <= 1'b0;
            end else begin
                m_ov   <= 1'b1;
                m_res  <= m_e.val;
                m_zero <= (m_e.val == 32'd0);
                m_ill  <= m_e.ill;
            end
        end else if (bus.out_ready) begin
            m_ov <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("in_ready", bus.in_ready, !reset && (m_busy == 0) && (!m_ov || bus.out_ready));
            check("out_valid", bus.out_valid, m_ov);
            check("result", bus.result, m_res);
            check("zero", bus.zero, m_zero);
            check("illegal_op", bus.illegal_op, m_ill);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.op_a     = a;
        bus.op_b     = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                step();
                bus.in_valid = 1'b0;
                return;
            end
            step();
        end
        check("issue_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    // Edges counted after the accept edge until out_valid is observed high.
    task automatic wait_result(input string name, input logic [31:0] exp_res, input logic exp_zero,
                               input logic exp_ill, input int exp_edges);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                lat  = i;
            end else begin
                step();
            end
        end
        check({name, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({name, "_edges"}, lat, exp_edges);
            check({name, "_result"}, bus.result, exp_res);
            check({name, "_zero"}, bus.zero, exp_zero);
            check({name, "_illegal"}, bus.illegal_op, exp_ill);
            step();
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.alu_op    = 4'd0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.out_ready = 1'b1;

        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 32'd0);
        check("rst_out_valid", bus.out_valid, 32'd0);
        check("rst_result", bus.result, 32'd0);
        step();
        reset = 1'b0;
        step();

        issue(4'd2, 32'hF0F0F0F0, 32'h0FF00FF0);
        wait_result("and", 32'h00F000F0, 1'b0, 1'b0, 0);
        issue(4'd9, 32'h80000000, 32'd4);
        wait_result("sra4", 32'hF8000000, 1'b0, 1'b0, 4);
        issue(4'd8, 32'h80000000, 32'd4);
        wait_result("srl4", 32'h08000000, 1'b0, 1'b0, 4);
        issue(4'd5, 32'hFFFFFFFF, 32'd1);
        wait_result("slt", 32'd1, 1'b0, 1'b0, 0);
        issue(4'd6, 32'hFFFFFFFF, 32'd1);
        wait_result("sltu", 32'd0, 1'b1, 1'b0, 0);
        issue(4'd1, 32'd5, 32'd5);
        wait_result("sub", 32'd0, 1'b1, 1'b0, 0);

        // Backpressure, then consume and accept on the same edge.
        bus.out_ready = 1'b0;
        issue(4'd0, 32'd3, 32'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", bus.out_valid, 32'd1);
            check("bp_result", bus.result, 32'd7);
            check("bp_in_ready", bus.in_ready, 32'd0);
            step();
        end
        bus.in_valid  = 1'b1;
        bus.alu_op    = 4'd4;
        bus.op_a      = 32'hFF;
        bus.op_b      = 32'h0F;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("b2b_in_ready", bus.in_ready, 32'd1);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("b2b_valid", bus.out_valid, 32'd1);
        check("b2b_result", bus.result, 32'hF0);
        step();

        // Reset in the middle of a long shift.
        issue(4'd7, 32'd1, 32'd31);
        repeat (9) step();
        reset = 1'b1;
        step();
        @(negedge clk);
        check("mid_rst_valid", bus.out_valid, 32'd0);
        check("mid_rst_result", bus.result, 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 32'd1);
        step();
        issue(4'd0, 32'd1, 32'd1);
        wait_result("add_after_rst", 32'd2, 1'b0, 1'b0, 0);

        issue(4'd12, 32'h1234, 32'h5678);
        wait_result("illegal", 32'd0, 1'b1, 1'b1, 0);
        issue(4'd7, 32'h12345678, 32'h00000020);
        wait_result("sll0", 32'h12345678, 1'b0, 1'b0, 0);
        issue(4'd7, 32'd1, 32'd31);
        wait_result("sll31", 32'h80000000, 1'b0, 1'b0, 31);

        // Randomized traffic; the per-cycle compare against the model does the checking.
        for (int c = 0; c < 4000; c++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.alu_op    = op;
            bus.op_a      = $urandom;
            bus.op_b      = ($urandom_range(0, 5) == 0) ? bus.op_a : $urandom;
            if ($urandom_range(0, 2) == 0) bus.op_b[4:0] = 5'($urandom_range(0, 3));
            reset         = ($urandom_range(0, 299) == 0);
            step();
        end
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
